// File: rtl/counter_checker.sv
// Sequence checker for the two-phase {x, y} counter stream: tracks lock,
// counts completed wraps and protocol errors, and reports a registered health word.
module counter_checker #(
  parameter int W     = 8,
  parameter int X_MAX = 8,
  parameter int Y_MAX = 6
) (
  input  logic           _i_clk,
  input  logic           _i_rst,
  input  logic [2*W-1:0] _i_xy,
  input  logic           _i_clear,
  output logic [2*W+3:0] __output
);

  localparam logic [W-1:0] XM = W'(X_MAX);
  localparam logic [W-1:0] YM = W'(Y_MAX);

  typedef enum logic {ACQUIRE = 1'b0, LOCKED = 1'b1} state_t;

  state_t         state_p1, state_nx;
  logic [W-1:0]   px_p1, py_p1, px_nx, py_nx;
  logic [W-1:0]   wraps_p1, wraps_nx, errs_p1, errs_nx;
  logic           err_sticky_p1, err_sticky_nx;
  logic [1:0]     phase_p1, phase_nx;
  logic [W-1:0]   sx, sy, ex, ey;
  logic           legal, match, wrap_edge;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == {W{1'b1}}) ? v : v + W'(1);
  endfunction

  function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] v);
    return v + W'(1);
  endfunction

  // Stage 0: classify the incoming sample against the stored predecessor
  always_comb begin
    sx        = _i_xy[2*W-1:W];
    sy        = _i_xy[W-1:0];
    legal     = ((sx <= XM) && (sy == '0)) ||
                ((sx == XM) && (sy != '0) && (sy <= YM));
    ex        = '0;
    ey        = '0;
    if ((py_p1 == '0) && (px_p1 < XM)) begin
      ex = wrap_inc(px_p1);
    end else if ((px_p1 == XM) && (py_p1 < YM)) begin
      ex = XM;
      ey = wrap_inc(py_p1);
    end
    wrap_edge = (px_p1 == XM) && (py_p1 == YM);
    match     = (sx == ex) && (sy == ey);
  end

  // Next-state and counter updates; clear zeroes first so a same-cycle event lands on zero
  always_comb begin
    state_nx      = state_p1;
    px_nx         = px_p1;
    py_nx         = py_p1;
    wraps_nx      = _i_clear ? '0 : wraps_p1;
    errs_nx       = _i_clear ? '0 : errs_p1;
    err_sticky_nx = _i_clear ? 1'b0 : err_sticky_p1;

    if (state_p1 == ACQUIRE) begin
      if (legal) begin
        state_nx = LOCKED;
        px_nx    = sx;
        py_nx    = sy;
      end
    end else begin
      if (match) begin
        px_nx = sx;
        py_nx = sy;
        if (wrap_edge) wraps_nx = wrap_inc(wraps_nx);
      end else begin
        state_nx      = ACQUIRE;
        errs_nx       = sat_inc(errs_nx);
        err_sticky_nx = 1'b1;
      end
    end

    if (state_nx == ACQUIRE) phase_nx = 2'b00;
    else if (py_nx == '0)    phase_nx = 2'b01;
    else                     phase_nx = 2'b10;
  end

  // Stage 1: registered state and status
  always_ff @(posedge _i_clk or negedge _i_rst) begin
    if (!_i_rst) begin
      state_p1      <= ACQUIRE;
      px_p1         <= '0;
      py_p1         <= '0;
      wraps_p1      <= '0;
      errs_p1       <= '0;
      err_sticky_p1 <= 1'b0;
      phase_p1      <= 2'b00;
    end else begin
      state_p1      <= state_nx;
      px_p1         <= px_nx;
      py_p1         <= py_nx;
      wraps_p1      <= wraps_nx;
      errs_p1       <= errs_nx;
      err_sticky_p1 <= err_sticky_nx;
      phase_p1      <= phase_nx;
    end
  end

  assign __output = {wraps_p1, errs_p1, phase_p1, err_sticky_p1, (state_p1 == LOCKED)};

endmodule
